riscv_mductrl: RTL
==================

Name: riscv_mductrl

Overview:
- Sequencer for the shared multi-cycle M-extension unit (multiplier/divider) in the execute stage.
- Decodes funcsel/mulctrl/divctrl for the instruction in E and issues a start pulse to the unit.
- Counts the unit's fixed latency and resolves divide special cases without starting the unit.
- Drives the pipeline stall to the hazard unit, plus a one-shot result-valid/result-select to the E-stage result mux.

Parameters:
- WIDTH, 64, operand width.
- MUL_LAT, 4, total cycles from issue to result for MUL* (>=2).
- DIV_LAT, 65, total cycles for 64-bit DIV/DIVU/REM/REMU (>=2).
- DIVW_LAT, 33, total cycles for DIVW/DIVUW/REMW/REMUW (>=2).

Ports:
- i_riscv_mductrl_clk, in, 1, clock.
- i_riscv_mductrl_rst, in, 1, reset. Asynchronous, active-low.
- i_riscv_mductrl_funcsel, in, 2, 00 ALU, 01 MUL, 10 DIV, 11 reserved (treated as ALU).
- i_riscv_mductrl_mulctrl, in, 3, multiply op code, latched on issue.
- i_riscv_mductrl_divctrl, in, 3, divide op code: 000 DIV, 001 DIVU, 010 REM, 011 REMU, 100 DIVW, 101 DIVUW, 110 REMW, 111 REMUW.
- i_riscv_mductrl_op1, in, WIDTH, forwarded operand A (dividend).
- i_riscv_mductrl_op2, in, WIDTH, forwarded operand B (divisor).
- i_riscv_mductrl_flush, in, 1, kill the E-stage instruction.
- i_riscv_mductrl_mstall, in, 1, downstream stall. The E/M register is not accepting.
- o_riscv_mductrl_start, out, 1, one-cycle start pulse to the unit.
- o_riscv_mductrl_opq, out, 3, latched mulctrl/divctrl for the unit.
- o_riscv_mductrl_isdiv, out, 1, latched: 1 = divide op, 0 = multiply op.
- o_riscv_mductrl_abort, out, 1, one-cycle abort to the unit.
- o_riscv_mductrl_stall, out, 1, stall request to the hazard unit.
- o_riscv_mductrl_resvalid, out, 1, the unit's result is valid this cycle.
- o_riscv_mductrl_special, out, 2, 00 normal, 01 divide-by-zero, 10 signed overflow.
- o_riscv_mductrl_resultsel, out, 2, E-result mux select: 00 ALU, 01 MUL, 10 DIV.

Behaviour:
- Reset (async, low):
  - State IDLE, counter 0.
  - All outputs 0.
  - resultsel = 00.
- States: IDLE, BUSY, DONE.
- Issue condition (IDLE only): funcsel is 01 or 10, and flush = 0.
- Normal issue cycle T0:
  - stall = 1, start = 1.
  - opq/isdiv latched.
  - counter loaded with LAT-1. LAT is MUL_LAT, DIV_LAT, or DIVW_LAT (divctrl[2] = 1).
  - Next state BUSY.
- BUSY:
  - stall = 1.
  - If counter == 1, go to DONE; otherwise decrement.
  - Result: exactly LAT stall cycles (T0..T(LAT-1)), DONE at cycle T(LAT).
- Special cases, divide only, evaluated at issue:
  - Divide-by-zero: divisor == 0. The divisor is the low 32 bits for W ops, else all WIDTH bits.
  - Signed overflow: signed op (divctrl[0] = 0), dividend = most-negative value, divisor = all ones. The W-op check uses the low 32 bits: 0x80000000 and 0xFFFFFFFF.
  - Divide-by-zero takes precedence.
  - On a special case: start = 0, go straight to DONE, stall = 1 for the issue cycle only. special is latched.
- DONE:
  - resvalid = 1, stall = 0.
  - resultsel = latched class (01/10). special is held.
  - If mstall = 1: stay in DONE, hold all outputs.
  - Else: next state IDLE. Clear special and resvalid. resultsel returns to 00.
  - No re-issue from DONE, even though funcsel still shows the same instruction.
- IDLE with funcsel 00/11:
  - stall = 0, resultsel = 00, no start.
- Flush (any state):
  - stall = 0 combinationally in the flush cycle. No resvalid in that cycle or afterwards for the killed op.
  - Next state IDLE, counter cleared.
  - abort = 1 for one cycle if the state was BUSY.
  - Flush in IDLE also suppresses issue.
  - Flush in DONE drops the result.
- start and abort are never both 1.
- start is never asserted while the state is BUSY or DONE.
- Reset mid-operation: immediate return to IDLE, outputs 0, no abort pulse.
- Counter width: $clog2(max LAT + 1).

Test Plan:
- MUL, MUL_LAT = 4, no stalls:
  - start at T0; stall = 1 at T0..T3.
  - At T4: resvalid = 1, resultsel = 01, stall = 0.
  - T5: back to IDLE, resultsel = 00.
- DIVW, op1 = 100, op2 = 7: stall for exactly 33 cycles, then resvalid with special = 00. DIV with the same operands: 65 cycles.
- DIVU with op2 = 0:
  - start never asserted; stall = 1 for one cycle.
  - Next cycle: resvalid = 1, special = 01.
- DIV, op1 = 0x8000000000000000, op2 = 0xFFFFFFFFFFFFFFFF: special = 10, one-cycle stall.
  - Same operands with DIVU: normal 65-cycle issue.
- DIV issued, flush at T10:
  - abort pulse at T10; stall = 0 at T10; IDLE at T11.
  - resvalid never asserted.
  - A new MUL issues at T11.
- MUL reaches DONE with mstall held high for 3 cycles: resvalid/resultsel held 3 cycles with no second start, then IDLE after mstall drops.

Source files
------------

// File: rtl/riscv_mductrl.sv
// Execute-stage sequencer for the shared multi-cycle multiply/divide unit:
// issues start, counts the fixed latency, resolves divide special cases.
module riscv_mductrl #(
  parameter int WIDTH    = 64,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 65,
  parameter int DIVW_LAT = 33
) (
  input  logic             i_riscv_mductrl_clk,
  input  logic             i_riscv_mductrl_rst,
  input  logic [1:0]       i_riscv_mductrl_funcsel,
  input  logic [2:0]       i_riscv_mductrl_mulctrl,
  input  logic [2:0]       i_riscv_mductrl_divctrl,
  input  logic [WIDTH-1:0] i_riscv_mductrl_op1,
  input  logic [WIDTH-1:0] i_riscv_mductrl_op2,
  input  logic             i_riscv_mductrl_flush,
  input  logic             i_riscv_mductrl_mstall,
  output logic             o_riscv_mductrl_start,
  output logic [2:0]       o_riscv_mductrl_opq,
  output logic             o_riscv_mductrl_isdiv,
  output logic             o_riscv_mductrl_abort,
  output logic             o_riscv_mductrl_stall,
  output logic             o_riscv_mductrl_resvalid,
  output logic [1:0]       o_riscv_mductrl_special,
  output logic [1:0]       o_riscv_mductrl_resultsel
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ?
                           ((MUL_LAT > DIVW_LAT) ? MUL_LAT : DIVW_LAT) :
                           ((DIV_LAT > DIVW_LAT) ? DIV_LAT : DIVW_LAT);
  localparam int CW = $clog2(MAX_LAT + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    opq_q;
  logic          isdiv_q;
  logic [1:0]    special_q;

  logic          is_mul, is_div, is_w, issue, div_zero, div_ovf;
  logic [1:0]    special_d;
  logic [2:0]    ctrl_d;
  logic [CW-1:0] lat_m1;

  always_comb begin
    is_mul   = (i_riscv_mductrl_funcsel == 2'b01);
    is_div   = (i_riscv_mductrl_funcsel == 2'b10);
    is_w     = i_riscv_mductrl_divctrl[2];
    // Issue is gated by reset so every output reads zero while reset is held.
    issue    = i_riscv_mductrl_rst && (state == IDLE) && (is_mul || is_div) &&
               !i_riscv_mductrl_flush;
    div_zero = is_w ? (i_riscv_mductrl_op2[31:0] == 32'd0)
                    : (i_riscv_mductrl_op2 == '0);
    div_ovf  = !i_riscv_mductrl_divctrl[0] &&
               (is_w ? ((i_riscv_mductrl_op1[31:0] == 32'h8000_0000) &&
                        (i_riscv_mductrl_op2[31:0] == 32'hFFFF_FFFF))
                     : ((i_riscv_mductrl_op1 == MOST_NEG) &&
                        (i_riscv_mductrl_op2 == '1)));
    special_d = 2'b00;
    if (is_div) begin
      if (div_zero)     special_d = 2'b01;
      else if (div_ovf) special_d = 2'b10;
    end
    ctrl_d = is_div ? i_riscv_mductrl_divctrl : i_riscv_mductrl_mulctrl;
    lat_m1 = is_mul ? CW'(MUL_LAT - 1) :
             is_w   ? CW'(DIVW_LAT - 1) : CW'(DIV_LAT - 1);
  end

  always_ff @(posedge i_riscv_mductrl_clk or negedge i_riscv_mductrl_rst) begin
    if (!i_riscv_mductrl_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      opq_q     <= 3'b000;
      isdiv_q   <= 1'b0;
      special_q <= 2'b00;
    end else if (i_riscv_mductrl_flush) begin
      state     <= IDLE;
      cnt       <= '0;
      special_q <= 2'b00;
    end else begin
      case (state)
        IDLE: if (issue) begin
          opq_q     <= ctrl_d;
          isdiv_q   <= is_div;
          special_q <= special_d;
          // Special cases bypass the unit and report on the next cycle.
          if (special_d != 2'b00) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            state <= BUSY;
            cnt   <= lat_m1;
          end
        end
        BUSY: begin
          if (cnt == CW'(1)) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: if (!i_riscv_mductrl_mstall) begin
          state     <= IDLE;
          special_q <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_riscv_mductrl_start     = issue && (special_d == 2'b00);
    o_riscv_mductrl_abort     = i_riscv_mductrl_flush && (state == BUSY);
    o_riscv_mductrl_stall     = !i_riscv_mductrl_flush && (issue || state == BUSY);
    o_riscv_mductrl_resvalid  = !i_riscv_mductrl_flush && (state == DONE);
    o_riscv_mductrl_resultsel = o_riscv_mductrl_resvalid ? (isdiv_q ? 2'b10 : 2'b01) : 2'b00;
    o_riscv_mductrl_special   = o_riscv_mductrl_resvalid ? special_q : 2'b00;
    // The unit sees the op code alongside start, then the latched copy.
    o_riscv_mductrl_opq       = issue ? ctrl_d : opq_q;
    o_riscv_mductrl_isdiv     = issue ? is_div : isdiv_q;
  end

endmodule
